// File: rtl/cpld_ramexp_pkg.sv
// CPC RAM expansion CPLD: shared encodings.
// FSM states, memory-map modes and 16K block indices.
package cpld_ramexp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    T1   = 2'b01,
    T2   = 2'b11,
    END  = 2'b10
  } wstate_e;

  localparam logic [2:0] MODE_C0 = 3'd0;
  localparam logic [2:0] MODE_C1 = 3'd1;
  localparam logic [2:0] MODE_C2 = 3'd2;
  localparam logic [2:0] MODE_C3 = 3'd3;
  localparam logic [2:0] MODE_C4 = 3'd4;
  localparam logic [2:0] MODE_C5 = 3'd5;
  localparam logic [2:0] MODE_C6 = 3'd6;
  localparam logic [2:0] MODE_C7 = 3'd7;

  localparam logic [1:0] BLK0 = 2'd0;
  localparam logic [1:0] BLK1 = 2'd1;
  localparam logic [1:0] BLK2 = 2'd2;
  localparam logic [1:0] BLK3 = 2'd3;

endpackage

// File: rtl/cpld_ramexp_bankmap.sv
// CPC RAM expansion CPLD: combinational map of mode/bank/block
// onto expansion or shadow SRAM.
module cpld_ramexp_bankmap
  import cpld_ramexp_pkg::*;
#(
  parameter int BANK_BITS   = 6,
  parameter int RAM_BANKS   = 64,
  parameter int SHADOW_MODE = 1,
  parameter int SHADOW_BANK = (1 << BANK_BITS) - 1
) (
  input  logic [2:0]           mode,
  input  logic [BANK_BITS-1:0] bank,
  input  logic [1:0]           blk,
  input  logic                 wr_b,
  output logic                 exp,
  output logic                 ramcs_b_r,
  output logic [BANK_BITS+1:0] ramadrhi
);

  localparam logic [BANK_BITS-1:0] SB = BANK_BITS'(SHADOW_BANK);

  logic [BANK_BITS-1:0] ebank;
  logic [1:0]           xblk;
  logic                 hit;
  logic                 sh_rd;
  logic                 unpop;

  // The shadow bank itself aliases onto its even neighbour
  always_comb begin
    ebank = bank;
    if (SHADOW_MODE != 0 && bank == SB)
      ebank[0] = 1'b0;
  end

  if (RAM_BANKS >= (1 << BANK_BITS)) begin : g_full
    assign unpop = 1'b0;
  end else begin : g_part
    assign unpop = ebank >= BANK_BITS'(RAM_BANKS);
  end

  always_comb begin
    hit   = 1'b0;
    sh_rd = 1'b0;
    xblk  = blk;
    unique case (mode)
      MODE_C0: hit = 1'b0;
      MODE_C1: begin
        hit  = blk == BLK3;
        xblk = BLK3;
      end
      MODE_C2: hit = 1'b1;
      MODE_C3: begin
        xblk  = BLK3;
        hit   = blk == BLK3 || (blk == BLK1 && !wr_b);
        sh_rd = blk == BLK1 && wr_b;
      end
      default: begin
        hit  = blk == BLK1;
        xblk = mode[1:0];
      end
    endcase
  end

  always_comb begin
    exp       = 1'b0;
    ramcs_b_r = 1'b1;
    ramadrhi  = {SB, blk};
    if (hit) begin
      exp       = 1'b1;
      ramcs_b_r = 1'b0;
      ramadrhi  = {ebank, xblk};
    end else if (SHADOW_MODE != 0) begin
      if (sh_rd) begin
        ramcs_b_r = 1'b0;
        ramadrhi  = {SB, BLK3};
      end else begin
        ramcs_b_r = !(!wr_b && blk == BLK3);
      end
    end
    if (unpop) begin
      exp       = 1'b0;
      ramcs_b_r = 1'b1;
    end
  end

endmodule

// File: rtl/cpld_ramexp_ctrl.sv
// CPC RAM expansion CPLD top: bank-select decode, memory map,
// write-cycle FSM with READY watchdog and 464 overdrive.
module cpld_ramexp_ctrl
  import cpld_ramexp_pkg::*;
#(
  parameter int BANK_BITS   = 6,
  parameter int RAM_BANKS   = 64,
  parameter int OVERDRIVE   = 1,
  parameter int SHADOW_MODE = 1,
  parameter int SHADOW_BANK = (1 << BANK_BITS) - 1,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 mreq_b,
  input  logic                 iorq_b,
  input  logic                 wr_b,
  input  logic                 rfsh_b,
  input  logic                 m1_b,
  input  logic                 ready,
  input  logic                 rd_b_in,
  input  logic                 adr15_in,
  input  logic                 adr14,
  input  logic [2:0]           ioadr,
  input  logic [7:0]           data,
  input  logic                 ramrd_b,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 ramcs_b,
  output logic                 ramoe_b,
  output logic                 ramwe_b,
  output logic                 ramdis,
  output logic                 rd_b_oe,
  output logic                 adr15_oe,
  output logic                 wdog_evt
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CLIM = CW'(WAIT_LIMIT - 1);

  logic                 iowr, iowr_q;
  logic [BANK_BITS-1:0] bank_d, bank_q, bank_c;
  logic [2:0]           mode_q, mode_c;
  logic                 mreq_b_q, adr15_q, ready_f_q;
  logic                 exp, exp_q, ramcs_b_r;
  logic                 start, wcyc;
  wstate_e              state, state_d;
  logic [CW-1:0]        cnt, cnt_d;

  assign iowr = !iorq_b && !wr_b && m1_b && !adr15_in
             && data[7:6] == 2'b11;

  if (BANK_BITS > 3) begin : g_ext
    assign bank_d = {~ioadr[BANK_BITS-4:0], data[5:3]};
  end else begin : g_base
    assign bank_d = data[5:3];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      iowr_q <= 1'b0;
      bank_q <= '0;
      mode_q <= '0;
    end else begin
      iowr_q <= iowr;
      if (iowr && !iowr_q) begin
        bank_q <= bank_d;
        mode_q <= data[2:0];
      end
    end
  end

  // Mapping copy only follows bank_q between memory cycles
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bank_c   <= '0;
      mode_c   <= '0;
      mreq_b_q <= 1'b1;
      exp_q    <= 1'b0;
    end else begin
      mreq_b_q <= mreq_b;
      if (mreq_b) begin
        bank_c <= bank_q;
        mode_c <= mode_q;
      end else begin
        exp_q <= exp;
      end
    end
  end

  always_ff @(negedge mreq_b or negedge reset_b) begin
    if (!reset_b) adr15_q <= 1'b0;
    else          adr15_q <= adr15_in;
  end

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) ready_f_q <= 1'b1;
    else          ready_f_q <= ready;
  end

  cpld_ramexp_bankmap #(
    .BANK_BITS  (BANK_BITS),
    .RAM_BANKS  (RAM_BANKS),
    .SHADOW_MODE(SHADOW_MODE),
    .SHADOW_BANK(SHADOW_BANK)
  ) u_map (
    .mode     (mode_c),
    .bank     (bank_c),
    .blk      ({adr15_q, adr14}),
    .wr_b     (wr_b),
    .exp      (exp),
    .ramcs_b_r(ramcs_b_r),
    .ramadrhi (ramadrhi)
  );

  assign start = !mreq_b && mreq_b_q && rfsh_b && rd_b_in;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    wdog_evt = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_d = T1;
        cnt_d   = '0;
      end
      T1: begin
        if (ready_f_q) begin
          state_d = T2;
        end else if (cnt == CLIM) begin
          state_d  = END;
          wdog_evt = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      T2: state_d = END;
      END: begin
        if (start) begin
          state_d = T1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wcyc = state == T1 || state == T2;

  // Once MREQ* rises the live map is stale, so hold the last cycle's hit
  assign rd_b_oe  = OVERDRIVE != 0 && wcyc && (mreq_b ? exp_q : exp);
  assign adr15_oe = OVERDRIVE != 0 && mode_c == MODE_C3 && !adr15_q
                 && adr14 && (SHADOW_MODE != 0 ? wcyc : !mreq_b);

  assign ramcs_b = ramcs_b_r || mreq_b || !rfsh_b;
  assign ramdis  = !ramcs_b_r;
  assign ramwe_b = wr_b;
  assign ramoe_b = ramrd_b || (OVERDRIVE != 0 && wcyc);

endmodule

// File: tb/tb_cpld_ramexp_ctrl.sv
// Directed bench for cpld_ramexp_ctrl; a second instance with
// only 8 populated banks covers the fall-through path.
module tb_cpld_ramexp_ctrl;

  logic       clk, reset_b;
  logic       mreq_b, iorq_b, wr_b, rfsh_b, m1_b, ready, rd_b_in;
  logic       adr15_in, adr14, ramrd_b;
  logic [2:0] ioadr;
  logic [7:0] data;

  logic [7:0] ramadrhi, u_ramadrhi;
  logic ramcs_b, ramoe_b, ramwe_b, ramdis, rd_b_oe, adr15_oe, wdog_evt;
  logic u_ramcs_b, u_ramoe_b, u_ramwe_b, u_ramdis;
  logic u_rd_b_oe, u_adr15_oe, u_wdog_evt;

  int n_chk = 0;
  int n_fail = 0;

  cpld_ramexp_ctrl dut (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
    .wr_b(wr_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .ready(ready),
    .rd_b_in(rd_b_in), .adr15_in(adr15_in), .adr14(adr14),
    .ioadr(ioadr), .data(data), .ramrd_b(ramrd_b),
    .ramadrhi(ramadrhi), .ramcs_b(ramcs_b), .ramoe_b(ramoe_b),
    .ramwe_b(ramwe_b), .ramdis(ramdis), .rd_b_oe(rd_b_oe),
    .adr15_oe(adr15_oe), .wdog_evt(wdog_evt)
  );

  cpld_ramexp_ctrl #(.RAM_BANKS(8)) dut_u (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
    .wr_b(wr_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .ready(ready),
    .rd_b_in(rd_b_in), .adr15_in(adr15_in), .adr14(adr14),
    .ioadr(ioadr), .data(data), .ramrd_b(ramrd_b),
    .ramadrhi(u_ramadrhi), .ramcs_b(u_ramcs_b), .ramoe_b(u_ramoe_b),
    .ramwe_b(u_ramwe_b), .ramdis(u_ramdis), .rd_b_oe(u_rd_b_oe),
    .adr15_oe(u_adr15_oe), .wdog_evt(u_wdog_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_out(input logic [2:0] ia, input logic [7:0] d);
    adr15_in = 1'b0;
    ioadr = ia;
    data = d;
    tick();
    iorq_b = 1'b0;
    wr_b = 1'b0;
    repeat (3) tick();
    iorq_b = 1'b1;
    wr_b = 1'b1;
    repeat (3) tick();
  endtask

  task automatic mem_rd(input logic a15, input logic a14);
    adr15_in = a15;
    adr14 = a14;
    #1;
    mreq_b = 1'b0;
    rd_b_in = 1'b0;
    #1;
  endtask

  task automatic wr_start(input logic a15, input logic a14);
    adr15_in = a15;
    adr14 = a14;
    #1;
    mreq_b = 1'b0;
    tick();
    wr_b = 1'b0;
    #1;
  endtask

  task automatic mem_end();
    mreq_b = 1'b1;
    wr_b = 1'b1;
    rd_b_in = 1'b1;
    ramrd_b = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int n_rd, n_wd;
    reset_b = 1'b0;
    mreq_b = 1'b1; iorq_b = 1'b1; wr_b = 1'b1; rfsh_b = 1'b1;
    m1_b = 1'b1; ready = 1'b1; rd_b_in = 1'b1; ramrd_b = 1'b1;
    adr15_in = 1'b0; adr14 = 1'b0; ioadr = 3'b000; data = 8'h00;
    tick();
    tick();
    chk("rst_rd_b_oe", rd_b_oe, 0);
    chk("rst_adr15_oe", adr15_oe, 0);
    chk("rst_wdog", wdog_evt, 0);
    chk("rst_ramcs_b", ramcs_b, 1);
    reset_b = 1'b1;
    tick();

    mem_rd(1, 1);
    chk("m0_rd_cs", ramcs_b, 1);
    chk("m0_rd_dis", ramdis, 0);
    chk("m0_rd_rdoe", rd_b_oe, 0);
    mem_end();

    io_out(3'b111, 8'hC2);
    mem_rd(1, 0);
    chk("b0_adrhi", ramadrhi, 8'h02);
    chk("b0_cs", ramcs_b, 0);
    rfsh_b = 1'b0;
    #1;
    chk("rfsh_cs", ramcs_b, 1);
    rfsh_b = 1'b1;
    mem_end();

    io_out(3'b110, 8'hC2);
    ramrd_b = 1'b0;
    wr_start(1, 0);
    chk("b8_adrhi", ramadrhi, 8'h22);
    chk("b8_t1_rdoe", rd_b_oe, 1);
    chk("b8_t1_oe", ramoe_b, 1);
    chk("b8_we", ramwe_b, 0);
    chk("b8_cs", ramcs_b, 0);
    tick();
    chk("b8_t2_rdoe", rd_b_oe, 1);
    mreq_b = 1'b1;
    wr_b = 1'b1;
    #1;
    chk("b8_hold_rdoe", rd_b_oe, 1);
    tick();
    chk("b8_end_rdoe", rd_b_oe, 0);
    chk("b8_end_oe", ramoe_b, 0);
    mem_end();

    io_out(3'b110, 8'hC3);
    adr15_in = 1'b0;
    adr14 = 1'b1;
    #1;
    mreq_b = 1'b0;
    #1;
    chk("m3_pre_a15oe", adr15_oe, 0);
    tick();
    wr_b = 1'b0;
    #1;
    chk("m3_wr_a15oe", adr15_oe, 1);
    chk("m3_wr_adrhi", ramadrhi, 8'h23);
    tick();
    mreq_b = 1'b1;
    wr_b = 1'b1;
    tick();
    chk("m3_end_a15oe", adr15_oe, 0);
    mem_end();
    mem_rd(0, 1);
    chk("m3_rd_adrhi", ramadrhi, 8'hFF);
    chk("m3_rd_cs", ramcs_b, 0);
    chk("m3_rd_dis", ramdis, 1);
    mem_end();

    io_out(3'b110, 8'hC5);
    mem_rd(0, 1);
    chk("m5_b1_adrhi", ramadrhi, 8'h21);
    chk("m5_b1_cs", ramcs_b, 0);
    mem_end();
    mem_rd(0, 0);
    chk("m5_b0_cs", ramcs_b, 1);
    chk("m5_b0_adrhi", ramadrhi, 8'hFC);
    mem_end();

    io_out(3'b000, 8'hFA);
    mem_rd(0, 0);
    chk("alias_adrhi", ramadrhi, 8'hF8);
    mem_end();

    io_out(3'b110, 8'hCA);
    mem_rd(1, 0);
    chk("pop_cs", ramcs_b, 0);
    chk("pop_adrhi", ramadrhi, 8'h26);
    chk("unpop_cs", u_ramcs_b, 1);
    chk("unpop_dis", u_ramdis, 0);
    mem_end();
    wr_start(1, 0);
    chk("unpop_rdoe", u_rd_b_oe, 0);
    chk("unpop_wr_cs", u_ramcs_b, 1);
    chk("pop_rdoe", rd_b_oe, 1);
    tick();
    mem_end();

    io_out(3'b110, 8'hC2);
    ready = 1'b0;
    wr_start(1, 0);
    n_rd = 0;
    n_wd = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_b_oe) n_rd++;
      if (wdog_evt) n_wd++;
      tick();
    end
    chk("wd_t1_clocks", n_rd, 15);
    chk("wd_pulses", n_wd, 1);
    chk("wd_rdoe_rel", rd_b_oe, 0);
    ready = 1'b1;
    mem_end();

    io_out(3'b110, 8'hC3);
    ready = 1'b0;
    wr_start(0, 1);
    chk("pre_rst_rdoe", rd_b_oe, 1);
    chk("pre_rst_a15oe", adr15_oe, 1);
    reset_b = 1'b0;
    #1;
    chk("rst_mid_rdoe", rd_b_oe, 0);
    chk("rst_mid_a15oe", adr15_oe, 0);
    ready = 1'b1;
    mreq_b = 1'b1;
    wr_b = 1'b1;
    tick();
    reset_b = 1'b1;
    tick();
    tick();
    mem_rd(1, 0);
    chk("post_rst_cs", ramcs_b, 1);
    chk("post_rst_adrhi", ramadrhi, 8'hFE);
    chk("post_rst_dis", ramdis, 0);
    mem_end();
    wr_start(1, 1);
    chk("shw_cs", ramcs_b, 0);
    chk("shw_dis", ramdis, 1);
    chk("shw_adrhi", ramadrhi, 8'hFF);
    chk("shw_rdoe", rd_b_oe, 0);
    tick();
    mem_end();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
